// File: rtl/dspl_pkg.sv
// Shared types and segment table for the dspl_scan_drv display scanner.
// Segment bits are {a,b,c,d,e,f,g}, active-high; the driver inverts for the pins.
package dspl_pkg;

    localparam int DIGIT_W = 6;

    typedef struct packed {
        logic       en;
        logic [3:0] hex;
        logic       dp;
    } digit_t;

    // Hex font: b and d are drawn lowercase so they differ from 8 and 0.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79,
        7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F,
        7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] hex);
        return SEG_LUT[hex];
    endfunction

endpackage

// File: rtl/dspl_scan_tmr.sv
// Scan timebase: slot counter within a digit and the digit index, with frame
// start (first slot of digit 0) and frame last (final slot of the last digit).
module dspl_scan_tmr #(
    parameter int NDIG            = 8,
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int SLOT_W          = $clog2(TICKS_PER_DIGIT),
    parameter int IDX_W           = $clog2(NDIG)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic [IDX_W-1:0]  idx_o,
    output logic [SLOT_W-1:0] slot_cnt_o,
    output logic              frame_start_o,
    output logic              frame_last_o
);

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              slot_wrap;
    logic              idx_wrap;

    assign slot_wrap = (slot_q == SLOT_W'(TICKS_PER_DIGIT - 1));
    assign idx_wrap  = (idx_q == IDX_W'(NDIG - 1));

    always_comb begin
        slot_d = slot_q;
        idx_d  = idx_q;
        if (slot_wrap) begin
            slot_d = '0;
            idx_d  = idx_wrap ? '0 : idx_q + IDX_W'(1);
        end else begin
            slot_d = slot_q + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q <= '0;
            idx_q  <= '0;
        end else begin
            slot_q <= slot_d;
            idx_q  <= idx_d;
        end
    end

    assign idx_o         = idx_q;
    assign slot_cnt_o    = slot_q;
    assign frame_start_o = (idx_q == '0) && (slot_q == '0);
    assign frame_last_o  = slot_wrap && idx_wrap;

endmodule

// File: rtl/dspl_scan_drv.sv
// Time-multiplexed 7-segment scan driver with frame-coherent snapshot, PWM
// brightness and blanking. Define DSPL_BLINK_EN to build per-digit blinking.
module dspl_scan_drv
    import dspl_pkg::*;
#(
    parameter int NDIG            = 8,
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int BLINK_FRAMES    = 250
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [DIGIT_W*NDIG-1:0] digits_i,
    input  logic [2:0]              bright_i,
    input  logic                    blank_i,
    input  logic [NDIG-1:0]         blink_mask_i,
    output logic [NDIG-1:0]         an_o,
    output logic [7:0]              dec_cat_o,
    output logic                    frame_strobe_o
);

    localparam int SLOT_W = $clog2(TICKS_PER_DIGIT);
    localparam int IDX_W  = $clog2(NDIG);
    localparam int LIM_W  = 35;

    logic [IDX_W-1:0]  idx;
    logic [SLOT_W-1:0] slot_cnt;
    logic              frame_start;
    logic              frame_last;

    dspl_scan_tmr #(
        .NDIG            (NDIG),
        .TICKS_PER_DIGIT (TICKS_PER_DIGIT),
        .SLOT_W          (SLOT_W),
        .IDX_W           (IDX_W)
    ) u_tmr (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .idx_o         (idx),
        .slot_cnt_o    (slot_cnt),
        .frame_start_o (frame_start),
        .frame_last_o  (frame_last)
    );

    logic [DIGIT_W*NDIG-1:0] snap_q;
    logic [2:0]              bright_q;
    logic [NDIG-1:0]         an_q, an_d;
    logic [7:0]              dec_cat_q, dec_cat_d;
    logic                    frame_strobe_q;

    // The frame-start slot must already show the new snapshot, so bypass the
    // snapshot registers in the very cycle they are being loaded.
    logic [DIGIT_W*NDIG-1:0] eff_digits;
    logic [2:0]              eff_bright;
    assign eff_digits = frame_start ? digits_i : snap_q;
    assign eff_bright = frame_start ? bright_i : bright_q;

    digit_t dig [NDIG];
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_unpack
        assign dig[gi] = eff_digits[DIGIT_W*gi +: DIGIT_W];
    end

    logic blink_phase;

`ifdef DSPL_BLINK_EN
    localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BF_W-1:0] frame_cnt_q;
    logic            blink_phase_q;

    // Advancing on the last cycle of a frame means the new phase is in place
    // exactly when the next frame's first slot is evaluated.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (frame_last) begin
            if (frame_cnt_q == BF_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                frame_cnt_q <= frame_cnt_q + BF_W'(1);
            end
        end
    end

    assign blink_phase = blink_phase_q;
`else
    localparam int UNUSED_BLINK_FRAMES = BLINK_FRAMES;
    logic unused_frame_last;
    assign unused_frame_last = frame_last;
    assign blink_phase       = 1'b0;
`endif

    digit_t           cur;
    logic [LIM_W-1:0] duty_lim;
    logic             in_window;
    logic             lit;

    assign cur       = dig[idx];
    assign duty_lim  = ((LIM_W'(eff_bright) + LIM_W'(1)) * LIM_W'(TICKS_PER_DIGIT)) >> 3;
    assign in_window = (LIM_W'(slot_cnt) < duty_lim);
    assign lit       = cur.en && !blank_i && in_window && !(blink_phase && blink_mask_i[idx]);

    always_comb begin
        an_d      = '1;
        dec_cat_d = 8'hFF;
        if (lit) begin
            an_d      = ~(NDIG'(1) << idx);
            dec_cat_d = {~seg_decode(cur.hex), ~cur.dp};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            snap_q         <= '0;
            bright_q       <= 3'd7;
            an_q           <= '1;
            dec_cat_q      <= 8'hFF;
            frame_strobe_q <= 1'b0;
        end else begin
            if (frame_start) begin
                snap_q   <= digits_i;
                bright_q <= bright_i;
            end
            an_q           <= an_d;
            dec_cat_q      <= dec_cat_d;
            frame_strobe_q <= frame_start;
        end
    end

    assign an_o           = an_q;
    assign dec_cat_o      = dec_cat_q;
    assign frame_strobe_o = frame_strobe_q;

endmodule

// File: tb/tb_dspl_scan_drv.sv
// Scoreboard bench for dspl_scan_drv (NDIG=4, TICKS_PER_DIGIT=8, BLINK_FRAMES=2);
// the blink expectations follow DSPL_BLINK_EN if it is defined for the build.
module tb_dspl_scan_drv;

    localparam int NDIG  = 4;
    localparam int TPD   = 8;
    localparam int BF    = 2;
    localparam int FRAME = NDIG * TPD;
`ifdef DSPL_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] digits;
    logic [2:0]  bright;
    logic        blank;
    logic [3:0]  mask;
    logic [3:0]  an;
    logic [7:0]  dec_cat;
    logic        frame_strobe;

    always #5 clk = ~clk;

    dspl_scan_drv #(
        .NDIG            (NDIG),
        .TICKS_PER_DIGIT (TPD),
        .BLINK_FRAMES    (BF)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .digits_i       (digits),
        .bright_i       (bright),
        .blank_i        (blank),
        .blink_mask_i   (mask),
        .an_o           (an),
        .dec_cat_o      (dec_cat),
        .frame_strobe_o (frame_strobe)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] cat;
        logic       strobe;
    } exp_t;

    exp_t        sb_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          m_pos, m_frames;
    logic [23:0] m_snap;
    logic [2:0]  m_bright;

    // Active-low a..g patterns for each hex value.
    function automatic logic [6:0] seg_low(input logic [3:0] h);
        case (h)
            4'h0: return 7'h01;  4'h1: return 7'h4F;  4'h2: return 7'h12;  4'h3: return 7'h06;
            4'h4: return 7'h4C;  4'h5: return 7'h24;  4'h6: return 7'h20;  4'h7: return 7'h0F;
            4'h8: return 7'h00;  4'h9: return 7'h04;  4'hA: return 7'h08;  4'hB: return 7'h60;
            4'hC: return 7'h31;  4'hD: return 7'h42;  4'hE: return 7'h30;  default: return 7'h38;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_pos    = 0;
        m_frames = 0;
        m_snap   = '0;
        m_bright = 3'd7;
        sb_q.delete();
    endtask

    // One clock: predict the registered outputs for this edge, then compare.
    task automatic tick();
        exp_t       e;
        int         idx, slot;
        logic [5:0] d;
        logic       phase, lit;
        if (m_pos == 0) begin
            m_snap   = digits;
            m_bright = bright;
        end
        idx   = m_pos / TPD;
        slot  = m_pos % TPD;
        d     = m_snap[6*idx +: 6];
        phase = BLINK_ON && (((m_frames / BF) % 2) == 1);
        lit   = d[5] && !blank && (slot * 8 < (int'(m_bright) + 1) * TPD) && !(phase && mask[idx]);
        e.an     = lit ? ~(4'b0001 << idx) : 4'hF;
        e.cat    = lit ? {seg_low(d[4:1]), ~d[0]} : 8'hFF;
        e.strobe = (m_pos == 0);
        sb_q.push_back(e);
        m_pos++;
        if (m_pos == FRAME) begin
            m_pos = 0;
            m_frames++;
        end
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        $display("t=%0t an=%b cat=%h strobe=%b (exp %b %h %b)", $time, an, dec_cat, frame_strobe, e.an, e.cat, e.strobe);
        chk("sb_an", 8'(an), 8'(e.an));
        chk("sb_cat", dec_cat, e.cat);
        chk("sb_strobe", 8'(frame_strobe), 8'(e.strobe));
    endtask

    task automatic wait_strobe(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_strobe && n < 100);
    endtask

    initial begin
        int n, low0, lit_all, lit0, lit1, exp0;
        digits = {6'b1_1000_0, 6'b0_0101_0, 6'b1_1010_1, 6'b1_0000_0};
        bright = 3'd7;
        blank  = 1'b0;
        mask   = 4'b0000;
        model_reset();

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_an", 8'(an), 8'h0F);
            chk("rst_cat", dec_cat, 8'hFF);
            chk("rst_strobe", 8'(frame_strobe), 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;

        tick();
        chk("first_strobe", 8'(frame_strobe), 8'h01);
        chk("slot0_an", 8'(an), 8'h0E);
        chk("slot0_cat", dec_cat, 8'h03);
        repeat (8) tick();
        chk("slot1_an", 8'(an), 8'h0D);
        chk("slot1_cat", dec_cat, 8'h10);
        repeat (8) tick();
        chk("dis_an", 8'(an), 8'h0F);
        chk("dis_cat", dec_cat, 8'hFF);
        wait_strobe(n);
        chk("strobe_gap16", 8'(n), 8'd16);
        wait_strobe(n);
        chk("strobe_period", 8'(n), 8'd32);

        // Coherence: change digit0 while digit0 is being scanned.
        repeat (2) tick();
        digits[5:0] = 6'b1_0001_0;
        tick();
        chk("coh_old", dec_cat, 8'h03);
        wait_strobe(n);
        chk("coh_gap", 8'(n), 8'd29);
        chk("coh_new_an", 8'(an), 8'h0E);
        chk("coh_new_cat", dec_cat, 8'h9F);

        // Brightness 1 of 7: two lit cycles per enabled digit.
        bright = 3'd1;
        wait_strobe(n);
        chk("bright_period", 8'(n), 8'd32);
        low0    = (an[0] == 1'b0) ? 1 : 0;
        lit_all = (an != 4'hF) ? 1 : 0;
        repeat (FRAME - 1) begin
            tick();
            if (an[0] == 1'b0) low0++;
            if (an != 4'hF) lit_all++;
        end
        chk("bright_d0", 8'(low0), 8'd2);
        chk("bright_all", 8'(lit_all), 8'd6);

        blank = 1'b1;
        tick();
        chk("blank_an", 8'(an), 8'h0F);
        wait_strobe(n);
        chk("blank_period", 8'(n), 8'd32);
        blank  = 1'b0;
        bright = 3'd7;

        // Blink on digit0 only, counted per whole frame.
        mask = 4'b0001;
        n = 0;
        while (m_pos != 0 && n < FRAME) begin
            tick();
            n++;
        end
        for (int f = 0; f < 6; f++) begin
            exp0 = (BLINK_ON && (((m_frames / BF) % 2) == 1)) ? 0 : TPD;
            lit0 = 0;
            lit1 = 0;
            repeat (FRAME) begin
                tick();
                if (an[0] == 1'b0) lit0++;
                if (an[1] == 1'b0) lit1++;
            end
            chk($sformatf("blink_d0_f%0d", f), 8'(lit0), 8'(exp0));
            chk($sformatf("blink_d1_f%0d", f), 8'(lit1), 8'(TPD));
        end
        mask = 4'b0000;

        // Asynchronous reset in the middle of a frame.
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_an", 8'(an), 8'h0F);
        chk("arst_cat", dec_cat, 8'hFF);
        chk("arst_strobe", 8'(frame_strobe), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick();
        chk("arst_restart_strobe", 8'(frame_strobe), 8'h01);
        chk("arst_restart_an", 8'(an), 8'h0E);
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
